// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_STALL  = 2'b11
    } pcsrc_e;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer holding {pc, instr} pairs between
// the memory response port and the decode stage.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign rdata = mem[rd_ptr];

    // Flush wins over push/pop so a redirect never leaves stale entries behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one in-flight imem read at a time, buffers
// responses in a 2-entry FIFO and handles branch/jalr redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target
);

    fetch_state_e state;
    fetch_state_e state_next;

    logic [31:0]                   fetch_pc;
    logic [31:0]                   pending_pc;
    logic                          outstanding;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    fetch_entry_t                  head;
    fetch_entry_t                  push_entry;

    pcsrc_e      sel;
    logic        consume;
    logic        redirect;
    logic        issue;
    logic        resp;
    logic        push;
    logic        pop;
    logic [31:0] target;

    assign sel         = pcsrc_e'(PCSrc);
    assign instr_valid = (fifo_count != '0) && (state == RUN);
    assign consume     = instr_valid && instr_ready && (sel != PC_STALL);
    assign redirect    = consume && ((sel == PC_BRANCH) || (sel == PC_JALR));
    assign target      = align_word((sel == PC_JALR) ? (jalr_target & ~32'h1) : branch_target);
    assign resp        = imem_valid && outstanding;

    // rst_n gates the request so the port reads idle while reset is held.
    assign issue = rst_n && (state == RUN) && !outstanding &&
                   ((int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH);

    assign push       = resp && (state == RUN) && !redirect;
    assign pop        = consume && !redirect;
    assign push_entry = '{pc: pending_pc, instr: imem_rdata};

    assign imem_req  = issue;
    assign imem_addr = issue ? fetch_pc : '0;
    assign instr     = instr_valid ? head.instr : '0;
    assign instr_pc  = instr_valid ? head.pc    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A redirect that leaves a stale read in flight (already outstanding, or
    // issued in this very cycle) must swallow that read's response in DROP.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (redirect && ((outstanding && !imem_valid) || issue)) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (resp) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            pending_pc  <= '0;
            outstanding <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= target;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (issue) begin
                pending_pc  <= fetch_pc;
                outstanding <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a simple latency-driven
// instruction memory model (data returned = ~address).
module tb_fetch_unit;

    localparam logic [1:0] SEL_PLUS4  = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JALR   = 2'b10;
    localparam logic [1:0] SEL_STALL  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  PCSrc;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;

    int checks = 0;
    int fails  = 0;

    int          mem_lat  = 1;
    bit          mem_busy = 0;
    bit          mem_hold = 0;
    int          mem_wait = 0;
    logic [31:0] mem_addr_q = '0;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .jalr_target   (jalr_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Memory model: a request seen this cycle is answered mem_lat cycles later.
    task automatic tick();
        if (imem_req === 1'b1) begin
            mem_busy   = 1;
            mem_addr_q = imem_addr;
            mem_wait   = mem_lat;
        end
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        imem_rdata = '0;
        if (mem_busy && !mem_hold) begin
            mem_wait--;
            if (mem_wait <= 0) begin
                imem_valid = 1'b1;
                imem_rdata = ~mem_addr_q;
                mem_busy   = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        instr_ready   = 1'b0;
        PCSrc         = SEL_PLUS4;
        imem_valid    = 1'b0;
        imem_rdata    = '0;
        branch_target = '0;
        jalr_target   = '0;
        mem_busy      = 0;
        mem_hold      = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        instr_ready   = 1'b1;
        PCSrc         = SEL_BRANCH;
        imem_valid    = 1'b0;
        imem_rdata    = '0;
        branch_target = 32'h40;
        jalr_target   = '0;
        mem_busy      = 0;
        mem_hold      = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({imem_req, instr_valid, imem_addr, instr, instr_pc} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got req=%b valid=%b addr=%h instr=%h pc=%h, expected all zero",
                     imem_req, instr_valid, imem_addr, instr, instr_pc);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_first_req: got req=%b addr=%h, expected req=1 addr=00000000",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b1;
        PCSrc       = SEL_PLUS4;
        for (int k = 0; k < 7; k++) begin
            exp_req   = (k % 2 == 0);
            exp_addr  = 32'(4 * (k / 2));
            exp_valid = (k > 0) && (k % 2 == 0);
            exp_pc    = 32'(4 * (k / 2 - 1));
            checks++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== exp_addr)) begin
                fails++;
                $display("[TB] FAIL stream_req k=%0d: got req=%b addr=%h, expected req=%b addr=%h",
                         k, imem_req, imem_addr, exp_req, exp_addr);
            end
            checks++;
            if (instr_valid !== exp_valid ||
                (exp_valid && (instr_pc !== exp_pc || instr !== ~exp_pc))) begin
                fails++;
                $display("[TB] FAIL stream_instr k=%0d: got valid=%b pc=%h instr=%h, expected valid=%b pc=%h instr=%h",
                         k, instr_valid, instr_pc, instr, exp_valid, exp_pc, ~exp_pc);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          nreq;
        int          idx;
        logic [31:0] got [4];
        do_reset();
        mem_lat       = 1;
        instr_ready   = 1'b0;
        PCSrc         = SEL_BRANCH;
        branch_target = 32'h200;
        nreq          = 0;
        for (int c = 0; c < 10; c++) begin
            if (imem_req === 1'b1) nreq++;
            tick();
        end
        checks++;
        if (nreq != 2 || imem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_requests: got %0d requests (req now %b), expected 2 (req now 0)",
                     nreq, imem_req);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            fails++;
            $display("[TB] FAIL bp_head: got valid=%b pc=%h, expected valid=1 pc=00000000",
                     instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        PCSrc       = SEL_PLUS4;
        idx         = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            if (instr_valid === 1'b1) begin
                got[idx] = instr_pc;
                idx++;
            end
            tick();
        end
        checks++;
        if (idx != 4) begin
            fails++;
            $display("[TB] FAIL bp_drain_count: got %0d instructions, expected 4", idx);
        end
        for (int i = 0; i < idx; i++) begin
            checks++;
            if (got[i] !== 32'(4 * i)) begin
                fails++;
                $display("[TB] FAIL bp_drain_order[%0d]: got pc=%h, expected %h", i, got[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b0;
        PCSrc       = SEL_PLUS4;
        repeat (3) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_valid !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_setup: got valid=%b pc=%h resp=%b req=%b, expected 1 00000000 1 0",
                     instr_valid, instr_pc, imem_valid, imem_req);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== ~32'h4 ||
            imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            fails++;
            $display("[TB] FAIL b2b_result: got valid=%b pc=%h instr=%h req=%b addr=%h, expected 1 00000004 fffffffb 1 00000008",
                     instr_valid, instr_pc, instr, imem_req, imem_addr);
        end
    endtask

    task automatic test_branch(input int lat, input logic [31:0] tgt, input bit expect_drop);
        bit seen_c;
        bit done;
        do_reset();
        mem_lat     = lat;
        instr_ready = 1'b1;
        PCSrc       = SEL_PLUS4;
        seen_c      = 0;
        done        = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (instr_valid === 1'b1 && instr_pc === 32'h8) begin
                if (seen_c && imem_req === 1'b0) begin
                    PCSrc         = SEL_BRANCH;
                    branch_target = tgt;
                    instr_ready   = 1'b1;
                    done          = 1;
                end else begin
                    instr_ready = 1'b0;
                end
            end else begin
                instr_ready = 1'b1;
                PCSrc       = SEL_PLUS4;
            end
            if (imem_req === 1'b1 && imem_addr === 32'hC) seen_c = 1;
            tick();
        end
        PCSrc       = SEL_PLUS4;
        instr_ready = 1'b1;
        checks++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL branch_trigger lat=%0d: got no consume at pc 8 with 0xC in flight, expected one", lat);
        end
        if (expect_drop) begin
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL branch_drop_cycle: got req=%b valid=%b, expected req=0 valid=0",
                         imem_req, instr_valid);
            end
            tick();
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL branch_next_req lat=%0d: got req=%b addr=%h valid=%b, expected req=1 addr=00000040 valid=0",
                     lat, imem_req, imem_addr, instr_valid);
        end
        for (int c = 0; c < 20 && instr_valid !== 1'b1; c++) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== ~32'h40) begin
            fails++;
            $display("[TB] FAIL branch_target_instr lat=%0d: got valid=%b pc=%h instr=%h, expected 1 00000040 ffffffbf",
                     lat, instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_jalr(input logic [31:0] trigger, input logic [31:0] jt, input logic [31:0] exp);
        bit done;
        bit stale;
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b1;
        PCSrc       = SEL_PLUS4;
        done        = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (instr_valid === 1'b1 && instr_pc === trigger) begin
                PCSrc       = SEL_JALR;
                jalr_target = jt;
                done        = 1;
            end
            tick();
        end
        PCSrc = SEL_PLUS4;
        checks++;
        if (!done) begin
            fails++;
            $display("[TB] FAIL jalr_trigger: got no instruction at pc %h, expected one", trigger);
        end
        stale = 0;
        for (int c = 0; c < 20 && imem_req !== 1'b1; c++) begin
            if (instr_valid === 1'b1) stale = 1;
            tick();
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp || stale) begin
            fails++;
            $display("[TB] FAIL jalr_next_req: got req=%b addr=%h stale=%b, expected req=1 addr=%h stale=0",
                     imem_req, imem_addr, stale, exp);
        end
        for (int c = 0; c < 20 && instr_valid !== 1'b1; c++) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== ~exp) begin
            fails++;
            $display("[TB] FAIL jalr_target_instr: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                     instr_valid, instr_pc, instr, exp, ~exp);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp + 32'h4) begin
            fails++;
            $display("[TB] FAIL jalr_following_req: got req=%b addr=%h, expected req=1 addr=%h",
                     imem_req, imem_addr, exp + 32'h4);
        end
    endtask

    task automatic test_stall();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b0;
        PCSrc       = SEL_PLUS4;
        repeat (4) tick();
        instr_ready   = 1'b1;
        PCSrc         = SEL_STALL;
        branch_target = 32'h80;
        jalr_target   = 32'h90;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== ~32'h0 || imem_req !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stall_hold k=%0d: got valid=%b pc=%h instr=%h req=%b, expected 1 00000000 ffffffff 0",
                         k, instr_valid, instr_pc, instr, imem_req);
            end
            tick();
        end
        PCSrc = SEL_PLUS4;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
            fails++;
            $display("[TB] FAIL stall_release: got valid=%b pc=%h, expected valid=1 pc=00000004",
                     instr_valid, instr_pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b0;
        PCSrc       = SEL_PLUS4;
        tick();
        tick();
        mem_hold = 1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_setup: got valid=%b pc=%h req=%b, expected 1 00000000 0",
                     instr_valid, instr_pc, imem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, imem_addr, instr, instr_pc} !== '0) begin
            fails++;
            $display("[TB] FAIL midreset_outputs: got req=%b valid=%b addr=%h instr=%h pc=%h, expected all zero",
                     imem_req, instr_valid, imem_addr, instr, instr_pc);
        end
        mem_busy = 0;
        mem_hold = 0;
        @(negedge clk);
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n      = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("[TB] FAIL midreset_restart: got req=%b addr=%h, expected req=1 addr=00000000",
                     imem_req, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_stray: got valid=%b pc=%h, expected valid=0", instr_valid, instr_pc);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== ~32'h0) begin
            fails++;
            $display("[TB] FAIL midreset_first_instr: got valid=%b pc=%h instr=%h, expected 1 00000000 ffffffff",
                     instr_valid, instr_pc, instr);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        instr_ready   = 1'b0;
        PCSrc         = SEL_PLUS4;
        imem_valid    = 1'b0;
        imem_rdata    = '0;
        branch_target = '0;
        jalr_target   = '0;
        $display("[TB] starting fetch_unit bench");
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_branch(2, 32'h40, 1'b1);
        test_branch(1, 32'h43, 1'b0);
        test_jalr(32'h4, 32'h103, 32'h100);
        test_jalr(32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
